pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Owns the program counter and sequences instruction fetch for the CPU.
//   - Holds the Z/N condition-flag register.
//   - Resolves BRZ/BRN/jump from the resolve stage and redirects the PC to the target.
//   - Squashes the younger in-flight instructions after a redirect.
//   - Honours hazard stalls.
//   Sits between decode/ALU control and the instruction-memory address port.
// PARAMETERS
//   PC_WIDTH     32  width of PC and branch target
//   RESET_PC     0   PC value loaded on reset
//   PC_STEP      1   sequential increment (word-addressed memory)
//   FLUSH_SLOTS  2   younger instructions squashed per redirect (1..7)
// PORTS
//   in_clk           in   1         clock; all state updates on rising edge
//   in_rst_n         in   1         asynchronous active-low reset
//   in_stall         in   1         hazard stall; hold PC, freeze flush count
//   in_resolve_valid in   1         instruction in resolve stage is valid
//   in_ctrl_branch   in   1         resolving instruction is a branch
//   in_ctrl_btype    in   1         0 = BRZ, 1 = BRN
//   in_ctrl_jump     in   1         resolving instruction is an unconditional jump
//   in_target        in   PC_WIDTH  branch/jump target address
//   in_flag_we       in   1         latch ALU flags this cycle
//   in_alu_neg       in   1         ALU negative result
//   in_alu_zero      in   1         ALU zero result
//   in_halt          in   1         HALT decoded (only with PCSEQ_HALT_EN)
//   out_pc           out  PC_WIDTH  fetch address
//   out_fetch_valid  out  1         out_pc is a real fetch this cycle
//   out_flush        out  1         squash the younger instruction(s) in the pipe
//   out_taken        out  1         redirect taken this cycle (combinational)
//   out_flag_neg     out  1         registered N flag
//   out_flag_zero    out  1         registered Z flag
//   out_halted       out  1         sequencer halted (tied 0 without macro)
// BEHAVIOUR
//   Reset (async assert, sync release):
//     out_pc=RESET_PC; flags=0; flush count=0; state=BOOT.
//     out_fetch_valid=0, out_flush=0, out_halted=0.
//   States:
//     BOOT  - one cycle, no fetch; goes to RUN.
//     RUN   - fetch_valid=1.
//     FLUSH - fetch_valid=1; out_flush=1 while flush count != 0.
//     HALT  - macro only.
//   Taken (combinational), where sq = squash active (flush count != 0):
//     taken = in_resolve_valid & ~sq & (jump | branch&~btype&Z | branch&btype&N)
//     Z and N are the registered flags. A flag write in the same cycle is
//     visible only from the next cycle; there is no bypass.
//   Next PC, in priority order:
//     1. reset
//     2. taken                     -> in_target
//     3. in_stall or state != RUN/FLUSH -> hold
//     4. otherwise                 -> out_pc + PC_STEP
//   Redirect timing: 1 cycle; out_pc shows the target on the edge after taken.
//   Wrap: PC arithmetic is mod 2^PC_WIDTH; all-ones + 1 -> 0.
//   A redirect takes priority over a stall in the same cycle.
//   On redirect:
//     - flush count loads FLUSH_SLOTS; state goes to FLUSH.
//     - The count decrements only on cycles with in_stall=0.
//     - At 0, state returns to RUN.
//   Resolves while sq=1 are ignored (squashed instructions).
//   Flags: if in_flag_we, N<=in_alu_neg and Z<=in_alu_zero; otherwise held.
//     Flags are updated during stall and flush.
//   Mid-operation reset clears the flush count and pending redirect immediately.
// CONFIGURATION
//   PCSEQ_HALT_EN defined:
//     - in_halt & in_resolve_valid & ~sq & ~taken -> HALT.
//     - In HALT: PC frozen, fetch_valid=0, out_halted=1.
//     - Exit HALT only by reset.
//   PCSEQ_HALT_EN undefined:
//     - in_halt ignored; out_halted tied 0; no HALT state.
// TESTING
//   - Reset, run 4 cycles -> BOOT then out_pc 0,1,2,3; fetch_valid 0,1,1,1.
//   - Flags Z=1; BRZ (branch=1, btype=0) target 0x40 -> out_taken=1.
//     Next out_pc=0x40; out_flush=1 for 2 cycles; a resolve in flush is ignored.
//   - Flags N=0; BRN -> out_taken=0, PC increments.
//     Set N=1 then BRN next cycle -> taken.
//   - in_stall=1 for 3 cycles in RUN -> out_pc constant.
//     Jump during stall -> PC=target; flush count frozen until stall drops.
//   - PC=0xFFFFFFFF, no branch -> next out_pc=0.
//     Assert in_rst_n=0 mid-flush -> outputs reset without waiting for a clock.
//   - With PCSEQ_HALT_EN: halt at PC=5 -> out_halted=1, fetch_valid=0, PC stays 5.
//     Taken jump + halt in the same cycle -> jump wins, no halt.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: Z/N flags, branch resolve, squash.
// Optional HALT state enabled by defining PCSEQ_HALT_EN.
module pc_sequencer #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned PC_STEP     = 1,
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic                in_clk,
  input  logic                in_rst_n,
  input  logic                in_stall,
  input  logic                in_resolve_valid,
  input  logic                in_ctrl_branch,
  input  logic                in_ctrl_btype,
  input  logic                in_ctrl_jump,
  input  logic [PC_WIDTH-1:0] in_target,
  input  logic                in_flag_we,
  input  logic                in_alu_neg,
  input  logic                in_alu_zero,
  input  logic                in_halt,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic                out_fetch_valid,
  output logic                out_flush,
  output logic                out_taken,
  output logic                out_flag_neg,
  output logic                out_flag_zero,
  output logic                out_halted
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
`ifdef PCSEQ_HALT_EN
    , HALT
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  neg_q, neg_d;
  logic                  zero_q, zero_d;
  logic                  sq;
  logic                  cond;
  logic                  halted;
  logic                  halt_go;

  assign sq   = (cnt_q != 3'd0);
  assign cond = in_ctrl_jump
              | (in_ctrl_branch & ~in_ctrl_btype & zero_q)
              | (in_ctrl_branch &  in_ctrl_btype & neg_q);

`ifdef PCSEQ_HALT_EN
  assign halted  = (state_q == HALT);
  assign halt_go = in_halt & in_resolve_valid & ~sq & ~out_taken & ~halted;
`else
  logic unused_halt;
  assign unused_halt = in_halt;
  assign halted  = 1'b0;
  assign halt_go = 1'b0;
`endif

  // Halted sequencer ignores redirects; only reset leaves HALT.
  assign out_taken = in_resolve_valid & ~sq & ~halted & cond;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    if (in_flag_we) begin
      neg_d  = in_alu_neg;
      zero_d = in_alu_zero;
    end
    if (out_taken) begin
      pc_d    = in_target;
      cnt_d   = 3'(FLUSH_SLOTS);
      state_d = FLUSH;
    end else if (halt_go) begin
`ifdef PCSEQ_HALT_EN
      state_d = HALT;
`endif
    end else begin
      if (!in_stall && (state_q == RUN || state_q == FLUSH))
        pc_d = pc_q + PC_WIDTH'(PC_STEP);
      case (state_q)
        BOOT: state_d = RUN;
        FLUSH: begin
          if (!in_stall && sq) cnt_d = cnt_q - 3'd1;
          if (cnt_d == 3'd0) state_d = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= 3'd0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
    end
  end

  assign out_pc          = pc_q;
  assign out_fetch_valid = (state_q == RUN) || (state_q == FLUSH);
  assign out_flush       = sq;
  assign out_flag_neg    = neg_q;
  assign out_flag_zero   = zero_q;
  assign out_halted      = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, branches, stalls, wrap, reset.
// Exercises the HALT feature when PCSEQ_HALT_EN is defined.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, rv, br, bt, jmp, fwe, aneg, azero, halt;
  logic [31:0] tgt;
  logic [31:0] pc;
  logic        fv, fl, tk, fn, fz, hl;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .in_clk          (clk),
    .in_rst_n        (rst_n),
    .in_stall        (stall),
    .in_resolve_valid(rv),
    .in_ctrl_branch  (br),
    .in_ctrl_btype   (bt),
    .in_ctrl_jump    (jmp),
    .in_target       (tgt),
    .in_flag_we      (fwe),
    .in_alu_neg      (aneg),
    .in_alu_zero     (azero),
    .in_halt         (halt),
    .out_pc          (pc),
    .out_fetch_valid (fv),
    .out_flush       (fl),
    .out_taken       (tk),
    .out_flag_neg    (fn),
    .out_flag_zero   (fz),
    .out_halted      (hl)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rv = 0; br = 0; bt = 0; jmp = 0; halt = 0; fwe = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    stall = 0; aneg = 0; azero = 0; tgt = '0;
    idle();
    do_reset();

    check("rst_pc", pc, 32'h0);
    check("boot_fv", {31'b0, fv}, 32'd0);
    check("rst_flush", {31'b0, fl}, 32'd0);
    check("rst_halted", {31'b0, hl}, 32'd0);
    check("rst_flags", {30'b0, fn, fz}, 32'd0);
    step();
    check("run0_pc", pc, 32'h0);
    check("run0_fv", {31'b0, fv}, 32'd1);
    step();
    check("run1_pc", pc, 32'h1);
    step();
    check("run2_pc", pc, 32'h2);

    fwe = 1; azero = 1; aneg = 0;
    step();
    fwe = 0;
    check("z_set", {31'b0, fz}, 32'd1);
    check("pc3", pc, 32'h3);

    rv = 1; br = 1; bt = 0; tgt = 32'h40;
    #1;
    check("brz_taken", {31'b0, tk}, 32'd1);
    step();
    check("brz_pc", pc, 32'h40);
    check("brz_flush0", {31'b0, fl}, 32'd1);
    br = 0; jmp = 1; tgt = 32'h99;
    #1;
    check("sq_ignored", {31'b0, tk}, 32'd0);
    step();
    check("flush1_pc", pc, 32'h41);
    check("flush1", {31'b0, fl}, 32'd1);
    idle();
    step();
    check("flush_done_pc", pc, 32'h42);
    check("flush_done", {31'b0, fl}, 32'd0);

    rv = 1; br = 1; bt = 1; tgt = 32'h80;
    fwe = 1; aneg = 1; azero = 0;
    #1;
    check("brn_n0", {31'b0, tk}, 32'd0);
    step();
    fwe = 0;
    check("brn_inc_pc", pc, 32'h43);
    check("n_set", {30'b0, fn, fz}, 32'd2);
    #1;
    check("brn_n1", {31'b0, tk}, 32'd1);
    step();
    check("brn_pc", pc, 32'h80);
    idle();
    step();
    step();
    check("post_brn_pc", pc, 32'h82);
    check("post_brn_fl", {31'b0, fl}, 32'd0);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc, 32'h82);
    end
    rv = 1; jmp = 1; tgt = 32'h200;
    #1;
    check("stall_jmp_tk", {31'b0, tk}, 32'd1);
    step();
    idle();
    check("stall_jmp_pc", pc, 32'h200);
    step();
    step();
    check("stall_hold_pc", pc, 32'h200);
    check("stall_hold_fl", {31'b0, fl}, 32'd1);
    stall = 0;
    step();
    check("unstall_pc", pc, 32'h201);
    check("unstall_fl", {31'b0, fl}, 32'd1);
    step();
    check("unstall_pc2", pc, 32'h202);
    check("unstall_fl2", {31'b0, fl}, 32'd0);

    rv = 1; jmp = 1; tgt = 32'hFFFF_FFFF;
    step();
    idle();
    check("max_pc", pc, 32'hFFFF_FFFF);
    step();
    check("wrap_pc", pc, 32'h0);
    step();
    rv = 1; jmp = 1; tgt = 32'h300;
    step();
    idle();
    check("pre_rst_pc", pc, 32'h300);
    check("pre_rst_fl", {31'b0, fl}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_fl", {31'b0, fl}, 32'd0);
    check("async_fv", {31'b0, fv}, 32'd0);
    check("async_flags", {30'b0, fn, fz}, 32'd0);
    step();
    rst_n = 1'b1;

`ifdef PCSEQ_HALT_EN
    repeat (6) step();
    check("pre_halt_pc", pc, 32'h5);
    rv = 1; halt = 1;
    step();
    idle();
    check("halted", {31'b0, hl}, 32'd1);
    check("halt_fv", {31'b0, fv}, 32'd0);
    step();
    check("halt_pc", pc, 32'h5);
    do_reset();
    step();
    rv = 1; jmp = 1; halt = 1; tgt = 32'h10;
    #1;
    check("jh_taken", {31'b0, tk}, 32'd1);
    step();
    idle();
    check("jh_pc", pc, 32'h10);
    check("jh_nohalt", {31'b0, hl}, 32'd0);
`else
    rv = 1; halt = 1;
    step();
    step();
    idle();
    check("nohalt_cfg", {31'b0, hl}, 32'd0);
    check("nohalt_fv", {31'b0, fv}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
